// File: rtl/fir_xifu_pkg.sv
// Shared types and constants for the FIR XIFU coprocessor writeback path.
package fir_xifu_pkg;

  localparam int unsigned FIR_XIFU_ID_WIDTH  = 4;
  localparam int unsigned FIR_XIFU_WB_DEPTH  = 4;

  typedef logic [FIR_XIFU_ID_WIDTH-1:0] x_id_t;

  typedef struct packed {
    logic        valid;
    x_id_t       id;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        we;
  } fir_xifu_ex2wb_t;

  typedef struct packed {
    x_id_t id;
    logic  commit_kill;
  } x_commit_t;

  typedef struct packed {
    x_id_t       id;
    logic [31:0] data;
    logic [4:0]  rd;
    logic        we;
    logic        exc;
    logic [5:0]  exccode;
    logic        err;
    logic        dbg;
  } x_result_t;

endpackage

// File: rtl/fir_xifu_wb_if.sv
// CV-X-IF commit and result channels as seen by the coprocessor and the core.
interface cv32e40x_if_xif;
  import fir_xifu_pkg::*;

  logic      commit_valid;
  x_commit_t commit;

  logic      result_valid;
  logic      result_ready;
  x_result_t result;

  modport coproc_commit (input commit_valid, input commit);
  modport coproc_result (output result_valid, output result, input result_ready);
  modport core_commit   (output commit_valid, output commit);
  modport core_result   (input result_valid, input result, output result_ready);

endinterface

// File: rtl/fir_xifu_wb_fifo.sv
// Generic in-order synchronous FIFO; full/empty come from the occupancy counter.
module fir_xifu_wb_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter type         T     = logic,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned CW   = AW + 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clear_i,
  input  logic          push_i,
  input  T              data_i,
  input  logic          pop_i,
  output T              head_o,
  output logic          empty_o,
  output logic          full_o,
  output logic [CW-1:0] count_o
);

  T              mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({push_i, pop_i})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i && !clear_i) mem_q[wr_ptr_q] <= data_i;
  end

  a_no_push_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(push_i && full_o && !pop_i));
  a_no_pop_empty: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(pop_i && empty_o));
  a_count_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
    count_q <= CW'(DEPTH));

endmodule

// File: rtl/fir_xifu_wb.sv
// Writeback stage: buffers EX completions and emits X-IF results for committed,
// non-killed offloads in order; killed entries are dropped one per cycle.
module fir_xifu_wb
  import fir_xifu_pkg::*;
#(
  parameter int unsigned DEPTH    = FIR_XIFU_WB_DEPTH,
  parameter int unsigned ID_WIDTH = FIR_XIFU_ID_WIDTH,
  localparam int unsigned CW      = $clog2(DEPTH) + 1
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        clear_i,
  input  fir_xifu_ex2wb_t             ex2wb_i,
  output logic                        ex2wb_ready_o,
  cv32e40x_if_xif.coproc_commit       xif_commit_i,
  cv32e40x_if_xif.coproc_result       xif_result_o,
  output logic [CW-1:0]               count_o
);

  localparam int unsigned NIDS = 2 ** ID_WIDTH;

  typedef enum logic [1:0] {
    HEAD_EMPTY,
    HEAD_WAIT,
    HEAD_READY,
    HEAD_DROP
  } head_state_e;

  fir_xifu_ex2wb_t   head;
  logic              empty, full, push, pop;
  head_state_e       head_state;
  logic [NIDS-1:0]   cmt_q, cmt_d, kill_q, kill_d;
  logic [ID_WIDTH-1:0] head_id, cmt_id;
  x_result_t         result;

  assign head_id       = ID_WIDTH'(head.id);
  assign cmt_id        = ID_WIDTH'(xif_commit_i.commit.id);
  assign push          = ex2wb_i.valid && !full;
  assign ex2wb_ready_o = !full;

  fir_xifu_wb_fifo #(
    .DEPTH (DEPTH),
    .T     (fir_xifu_ex2wb_t)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (clear_i),
    .push_i  (push),
    .data_i  (ex2wb_i),
    .pop_i   (pop),
    .head_o  (head),
    .empty_o (empty),
    .full_o  (full),
    .count_o (count_o)
  );

  always_comb begin
    head_state = HEAD_EMPTY;
    if (!empty) begin
      if (kill_q[head_id])     head_state = HEAD_DROP;
      else if (cmt_q[head_id]) head_state = HEAD_READY;
      else                     head_state = HEAD_WAIT;
    end
  end

  assign pop = (head_state == HEAD_DROP) ||
               ((head_state == HEAD_READY) && xif_result_o.result_ready);

  always_comb begin
    result = '0;
    if (head_state == HEAD_READY) begin
      result.id   = head.id;
      result.data = head.data;
      result.rd   = head.rd;
      result.we   = head.we;
    end
  end

  assign xif_result_o.result_valid = (head_state == HEAD_READY);
  assign xif_result_o.result       = result;

  // Clear on pop first, then apply the commit so a same-cycle reuse of the ID survives.
  always_comb begin
    cmt_d  = cmt_q;
    kill_d = kill_q;
    if (pop) begin
      cmt_d[head_id]  = 1'b0;
      kill_d[head_id] = 1'b0;
    end
    if (xif_commit_i.commit_valid) begin
      cmt_d[cmt_id] = 1'b1;
      if (xif_commit_i.commit.commit_kill) kill_d[cmt_id] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cmt_q  <= '0;
      kill_q <= '0;
    end else if (clear_i) begin
      cmt_q  <= '0;
      kill_q <= '0;
    end else begin
      cmt_q  <= cmt_d;
      kill_q <= kill_d;
    end
  end

  a_count_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
    count_o <= CW'(DEPTH));
  a_commit_fresh: assert property (@(posedge clk_i) disable iff (!rst_ni || clear_i)
    xif_commit_i.commit_valid |-> !cmt_q[cmt_id]);
  a_payload_stable: assert property (@(posedge clk_i) disable iff (!rst_ni || clear_i)
    (xif_result_o.result_valid && !xif_result_o.result_ready) |=>
      (xif_result_o.result_valid && $stable(xif_result_o.result)));

endmodule

// File: tb/tb_fir_xifu_wb.sv
// Directed bench for fir_xifu_wb with hand-computed expected results.
module tb_fir_xifu_wb;
  import fir_xifu_pkg::*;

  logic            clk_i = 1'b0;
  logic            rst_ni = 1'b0;
  logic            clear_i = 1'b0;
  fir_xifu_ex2wb_t ex2wb = '0;
  logic            ex2wb_ready;
  logic [2:0]      count;

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;

  cv32e40x_if_xif xif ();

  fir_xifu_wb #(.DEPTH(4), .ID_WIDTH(4)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .clear_i       (clear_i),
    .ex2wb_i       (ex2wb),
    .ex2wb_ready_o (ex2wb_ready),
    .xif_commit_i  (xif),
    .xif_result_o  (xif),
    .count_o       (count)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  task automatic drive_push(input logic v, input logic [3:0] id, input logic [4:0] rd,
                            input logic [31:0] data, input logic we);
    ex2wb.valid = v;
    ex2wb.id    = id;
    ex2wb.rd    = rd;
    ex2wb.data  = data;
    ex2wb.we    = we;
  endtask

  task automatic drive_commit(input logic v, input logic [3:0] id, input logic kill);
    xif.commit_valid       = v;
    xif.commit.id          = id;
    xif.commit.commit_kill = kill;
  endtask

  initial begin
    drive_commit(1'b0, 4'd0, 1'b0);
    xif.result_ready = 1'b0;
    #23 rst_ni = 1'b1;
    tick();

    // Reset state
    check("rst_count", 32'(count), 32'd0);
    check("rst_ready", 32'(ex2wb_ready), 32'd1);
    check("rst_valid", 32'(xif.result_valid), 32'd0);
    check("rst_data", xif.result.data, 32'd0);

    // 1: commit before push
    drive_commit(1'b1, 4'd3, 1'b0);
    tick();
    drive_commit(1'b0, 4'd0, 1'b0);
    drive_push(1'b1, 4'd3, 5'd5, 32'hDEADBEEF, 1'b1);
    xif.result_ready = 1'b1;
    #1 check("t1_no_bypass", 32'(xif.result_valid), 32'd0);
    tick();
    drive_push(1'b0, 4'd0, 5'd0, 32'd0, 1'b0);
    check("t1_valid", 32'(xif.result_valid), 32'd1);
    check("t1_id", 32'(xif.result.id), 32'd3);
    check("t1_rd", 32'(xif.result.rd), 32'd5);
    check("t1_data", xif.result.data, 32'hDEADBEEF);
    check("t1_we", 32'(xif.result.we), 32'd1);
    check("t1_count1", 32'(count), 32'd1);
    tick();
    check("t1_count0", 32'(count), 32'd0);
    check("t1_valid0", 32'(xif.result_valid), 32'd0);

    // 2: wait for late commit, hold under backpressure
    xif.result_ready = 1'b0;
    drive_push(1'b1, 4'd1, 5'd7, 32'h11111111, 1'b0);
    tick();
    drive_push(1'b0, 4'd0, 5'd0, 32'd0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      check("t2_wait", 32'(xif.result_valid), 32'd0);
      tick();
    end
    drive_commit(1'b1, 4'd1, 1'b0);
    tick();
    drive_commit(1'b0, 4'd0, 1'b0);
    check("t2_valid", 32'(xif.result_valid), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t2_hold_valid", 32'(xif.result_valid), 32'd1);
      check("t2_hold_data", xif.result.data, 32'h11111111);
      check("t2_hold_we", 32'(xif.result.we), 32'd0);
    end
    xif.result_ready = 1'b1;
    tick();
    check("t2_count0", 32'(count), 32'd0);

    // 3: commit 0, kill 1, commit 2
    xif.result_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_push(1'b1, 4'(i), 5'(i + 10), 32'hA000_0000 + 32'(i), 1'b1);
      tick();
    end
    drive_push(1'b0, 4'd0, 5'd0, 32'd0, 1'b0);
    check("t3_count3", 32'(count), 32'd3);
    drive_commit(1'b1, 4'd0, 1'b0); tick();
    drive_commit(1'b1, 4'd1, 1'b1); tick();
    drive_commit(1'b1, 4'd2, 1'b0); tick();
    drive_commit(1'b0, 4'd0, 1'b0);
    check("t3_valid_id0", 32'(xif.result_valid), 32'd1);
    check("t3_id0", 32'(xif.result.id), 32'd0);
    xif.result_ready = 1'b1;
    tick();
    check("t3_drop_valid", 32'(xif.result_valid), 32'd0);
    check("t3_count2", 32'(count), 32'd2);
    tick();
    check("t3_count1", 32'(count), 32'd1);
    check("t3_valid_id2", 32'(xif.result_valid), 32'd1);
    check("t3_id2", 32'(xif.result.id), 32'd2);
    check("t3_data2", xif.result.data, 32'hA000_0002);
    tick();
    check("t3_count0", 32'(count), 32'd0);
    check("t3_valid0", 32'(xif.result_valid), 32'd0);

    // 4: fill, then release head
    xif.result_ready = 1'b0;
    for (int i = 4; i < 8; i++) begin
      drive_push(1'b1, 4'(i), 5'(i), 32'hB000_0000 + 32'(i), 1'b1);
      tick();
    end
    drive_push(1'b0, 4'd0, 5'd0, 32'd0, 1'b0);
    check("t4_full_ready", 32'(ex2wb_ready), 32'd0);
    check("t4_count4", 32'(count), 32'd4);
    drive_commit(1'b1, 4'd4, 1'b0);
    xif.result_ready = 1'b1;
    tick();
    drive_commit(1'b0, 4'd0, 1'b0);
    check("t4_valid", 32'(xif.result_valid), 32'd1);
    check("t4_still_full", 32'(ex2wb_ready), 32'd0);
    tick();
    xif.result_ready = 1'b0;
    check("t4_ready_back", 32'(ex2wb_ready), 32'd1);
    check("t4_count3", 32'(count), 32'd3);

    // 5: refill with head committed, then clear with pop and push pending
    drive_commit(1'b1, 4'd5, 1'b0);
    drive_push(1'b1, 4'd8, 5'd8, 32'hB000_0008, 1'b1);
    tick();
    drive_commit(1'b0, 4'd0, 1'b0);
    check("t5_count4", 32'(count), 32'd4);
    check("t5_valid_id5", 32'(xif.result.id), 32'd5);
    clear_i = 1'b1;
    xif.result_ready = 1'b1;
    drive_push(1'b1, 4'd9, 5'd9, 32'hB000_0009, 1'b1);
    tick();
    clear_i = 1'b0;
    drive_push(1'b0, 4'd0, 5'd0, 32'd0, 1'b0);
    check("t5_clr_count", 32'(count), 32'd0);
    check("t5_clr_valid", 32'(xif.result_valid), 32'd0);
    check("t5_clr_ready", 32'(ex2wb_ready), 32'd1);
    drive_push(1'b1, 4'd5, 5'd3, 32'hC0DE_0005, 1'b1);
    tick();
    drive_push(1'b0, 4'd0, 5'd0, 32'd0, 1'b0);
    check("t5_sb_cleared", 32'(xif.result_valid), 32'd0);
    check("t5_count1", 32'(count), 32'd1);

    // 6: async reset while presenting a result
    xif.result_ready = 1'b0;
    drive_commit(1'b1, 4'd5, 1'b0);
    tick();
    drive_commit(1'b0, 4'd0, 1'b0);
    check("t6_valid", 32'(xif.result_valid), 32'd1);
    #3 rst_ni = 1'b0;
    #1 check("t6_rst_valid", 32'(xif.result_valid), 32'd0);
    #1 rst_ni = 1'b1;
    tick();
    check("t6_ready", 32'(ex2wb_ready), 32'd1);
    check("t6_count", 32'(count), 32'd0);
    check("t6_valid_after", 32'(xif.result_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
